// File: rtl/pwm_bank_if.sv
// Register-access bus between the command decoder and the PWM bank.
// Strobes are single-cycle; read data returns one cycle after cfg_re.
interface pwm_bank_if #(
  parameter int WIDTH = 8
);
  logic             cfg_we;
  logic             cfg_re;
  logic [4:0]       cfg_addr;
  logic [WIDTH-1:0] cfg_wdata;
  logic [WIDTH-1:0] cfg_rdata;
  logic             cfg_rvalid;

  modport master (
    output cfg_we, cfg_re, cfg_addr, cfg_wdata,
    input  cfg_rdata, cfg_rvalid
  );

  modport slave (
    input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
    output cfg_rdata, cfg_rvalid
  );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with double-buffered duty/mode registers.
// Shadow registers load active copies only at the period wrap, so updates are glitch-free.
module pwm_bank #(
  parameter int N_CH     = 3,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  pwm_bank_if.slave       cfg,
  output logic [N_CH-1:0] pwm_out_o,
  output logic            period_tick_o,
  output logic [N_CH-1:0] oneshot_done_o
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_PWM     = 2'd1,
    M_ONESHOT = 2'd2,
    M_ON      = 2'd3
  } mode_e;

  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_duty_q [N_CH];
  logic [WIDTH-1:0] sh_duty_d [N_CH];
  mode_e            sh_mode_q [N_CH];
  mode_e            sh_mode_d [N_CH];
  logic [WIDTH-1:0] act_duty_q [N_CH];
  logic [WIDTH-1:0] act_duty_d [N_CH];
  mode_e            act_mode_q [N_CH];
  mode_e            act_mode_d [N_CH];
  logic [WIDTH-1:0] rem_q [N_CH];
  logic [WIDTH-1:0] rem_d [N_CH];
  logic [N_CH-1:0]  arm_q, arm_d;
  logic [N_CH-1:0]  fin_q, fin_d;
  logic [N_CH-1:0]  pwm_q, pwm_d;
  logic [N_CH-1:0]  done_q, done_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             pre_tick_s;
  logic             wrap_s;
  logic [WIDTH-1:0] rd_val_s;
  logic [N_CH-1:0]  wr_duty_s;
  logic [N_CH-1:0]  wr_mode_s;

  // Next-state logic: timebase, per-channel mode engine, register access
  always_comb begin
    pre_tick_s = (pre_q == PRE_LAST);
    wrap_s     = pre_tick_s && (cnt_q == CNT_LAST);
    if (pre_tick_s) begin
      pre_d = '0;
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      pre_d = pre_q + PW'(1);
      cnt_d = cnt_q;
    end
    tick_d   = wrap_s;
    done_d   = fin_q;
    rd_val_s = '0;

    for (int i = 0; i < N_CH; i++) begin
      wr_duty_s[i]  = cfg.cfg_we && (cfg.cfg_addr == 5'(i));
      wr_mode_s[i]  = cfg.cfg_we && (cfg.cfg_addr == 5'(16 + i));
      sh_duty_d[i]  = sh_duty_q[i];
      sh_mode_d[i]  = sh_mode_q[i];
      act_duty_d[i] = act_duty_q[i];
      act_mode_d[i] = act_mode_q[i];
      rem_d[i]      = rem_q[i];
      arm_d[i]      = arm_q[i];
      fin_d[i]      = 1'b0;

      rd_val_s = rd_val_s
               | ((cfg.cfg_addr == 5'(i))      ? sh_duty_q[i] : '0)
               | ((cfg.cfg_addr == 5'(16 + i)) ? WIDTH'(sh_mode_q[i]) : '0);

      case (act_mode_q[i])
        M_OFF:     pwm_d[i] = 1'b0;
        M_PWM:     pwm_d[i] = (cnt_q < act_duty_q[i]);
        M_ONESHOT: pwm_d[i] = (rem_q[i] != '0);
        M_ON:      pwm_d[i] = 1'b1;
        default:   pwm_d[i] = 1'b0;
      endcase

      if (wrap_s) begin
        act_duty_d[i] = sh_duty_q[i];
        if (arm_q[i]) begin
          arm_d[i]      = 1'b0;
          act_mode_d[i] = M_ONESHOT;
          rem_d[i]      = sh_duty_q[i];
          if (sh_duty_q[i] == '0) begin
            fin_d[i]      = 1'b1;
            act_mode_d[i] = M_OFF;
            sh_mode_d[i]  = M_OFF;
          end else begin
            fin_d[i]      = 1'b0;
          end
        end else if ((act_mode_q[i] == M_ONESHOT) && (sh_mode_q[i] == M_ONESHOT)) begin
          // Last period of the train: drop output and retire the channel to OFF
          if (rem_q[i] <= WIDTH'(1)) begin
            rem_d[i]      = '0;
            fin_d[i]      = 1'b1;
            act_mode_d[i] = M_OFF;
            sh_mode_d[i]  = M_OFF;
          end else begin
            rem_d[i]      = rem_q[i] - WIDTH'(1);
          end
        end else begin
          act_mode_d[i] = sh_mode_q[i];
          rem_d[i]      = '0;
        end
      end else begin
        act_duty_d[i] = act_duty_q[i];
      end

      // Host writes take priority over the one-shot auto-clear
      if (wr_duty_s[i]) begin
        sh_duty_d[i] = cfg.cfg_wdata;
      end else begin
        sh_duty_d[i] = sh_duty_d[i];
      end
      if (wr_mode_s[i]) begin
        sh_mode_d[i] = mode_e'(cfg.cfg_wdata[1:0]);
        arm_d[i]     = (cfg.cfg_wdata[1:0] == 2'd2);
      end else begin
        sh_mode_d[i] = sh_mode_d[i];
      end
    end

    if (cfg.cfg_re) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val_s;
    end else begin
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      arm_q    <= '0;
      fin_q    <= '0;
      pwm_q    <= '0;
      done_q   <= '0;
      tick_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        sh_duty_q[i]  <= '0;
        sh_mode_q[i]  <= M_OFF;
        act_duty_q[i] <= '0;
        act_mode_q[i] <= M_OFF;
        rem_q[i]      <= '0;
      end
    end else begin
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      arm_q      <= arm_d;
      fin_q      <= fin_d;
      pwm_q      <= pwm_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      sh_duty_q  <= sh_duty_d;
      sh_mode_q  <= sh_mode_d;
      act_duty_q <= act_duty_d;
      act_mode_q <= act_mode_d;
      rem_q      <= rem_d;
    end
  end

  assign pwm_out_o      = pwm_q;
  assign period_tick_o  = tick_q;
  assign oneshot_done_o = done_q;
  assign cfg.cfg_rdata  = rdata_q;
  assign cfg.cfg_rvalid = rvalid_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank with N_CH=3, WIDTH=4, PRESCALE=2 (32-clk period).
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pwm_out;
  logic       period_tick;
  logic [2:0] oneshot_done;

  int n_vec = 0;
  int n_err = 0;

  int highs [3];
  int rises [3];
  int dones [3];
  int done_at [3];
  int fall_at [3];
  int ticks;
  int bad_gap;

  pwm_bank_if #(.WIDTH(4)) bus ();

  pwm_bank #(.N_CH(3), .WIDTH(4), .PRESCALE(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg            (bus),
    .pwm_out_o      (pwm_out),
    .period_tick_o  (period_tick),
    .oneshot_done_o (oneshot_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 5'(addr);
    bus.cfg_wdata = 4'(data);
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic cfg_read(input int addr, input int exp, input string tag);
    bus.cfg_re   = 1'b1;
    bus.cfg_addr = 5'(addr);
    @(negedge clk);
    bus.cfg_re   = 1'b0;
    check_val({tag, "_rvalid"}, int'(bus.cfg_rvalid), 1);
    check_val(tag, int'(bus.cfg_rdata), exp);
    @(negedge clk);
    check_val({tag, "_rvalid_drop"}, int'(bus.cfg_rvalid), 0);
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (period_tick) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("tick_wait", int'(seen), 1);
  endtask

  // Samples n cycles; optionally issues one write after sample mid_idx
  task automatic run(input int n, input int mid_idx, input int mid_addr, input int mid_data);
    logic [2:0] prev = pwm_out;
    int last_tick = 0;
    ticks   = 0;
    bad_gap = 0;
    for (int c = 0; c < 3; c++) begin
      highs[c] = 0; rises[c] = 0; dones[c] = 0; done_at[c] = -1; fall_at[c] = -1;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus.cfg_we = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (pwm_out[c]) highs[c]++;
        if (pwm_out[c] && !prev[c]) rises[c]++;
        if (!pwm_out[c] && prev[c] && fall_at[c] < 0) fall_at[c] = k;
        if (oneshot_done[c]) begin
          dones[c]++;
          done_at[c] = k;
        end
      end
      if (period_tick) begin
        ticks++;
        if (k - last_tick != 32) bad_gap++;
        last_tick = k;
      end
      prev = pwm_out;
      if (k == mid_idx) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 5'(mid_addr);
        bus.cfg_wdata = 4'(mid_data);
      end
    end
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    int rst_done;
    rst_n         = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_re    = 1'b0;
    bus.cfg_addr  = 5'd0;
    bus.cfg_wdata = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_val("rst_pwm", int'(pwm_out), 0);
    check_val("rst_tick", int'(period_tick), 0);
    check_val("rst_done", int'(oneshot_done), 0);
    check_val("rst_rvalid", int'(bus.cfg_rvalid), 0);
    check_val("rst_rdata", int'(bus.cfg_rdata), 0);

    // PWM duty 4 on channel 1: 8 clk high per 32
    cfg_write(1, 4);
    cfg_write(17, 1);
    wait_tick();
    run(32, -1, 0, 0);
    check_val("pwm1_high", highs[1], 8);
    check_val("pwm1_rise", rises[1], 1);
    check_val("pwm0_idle", highs[0], 0);
    check_val("pwm2_idle", highs[2], 0);
    run(32, -1, 0, 0);
    check_val("pwm1_high_p2", highs[1], 8);
    check_val("tick_at_end", int'(period_tick), 1);

    // Duty 15 then duty 0 mid-period on channel 2
    cfg_write(2, 15);
    cfg_write(18, 1);
    wait_tick();
    run(32, 16, 2, 0);
    check_val("pwm2_full", highs[2], 30);
    check_val("pwm2_rise", rises[2], 1);
    check_val("pwm1_steady", highs[1], 8);
    run(32, -1, 0, 0);
    check_val("pwm2_zero", highs[2], 0);
    check_val("pwm2_no_runt", rises[2], 0);

    // One-shot of 3 periods on channel 0
    cfg_write(0, 3);
    cfg_write(16, 2);
    wait_tick();
    run(128, -1, 0, 0);
    check_val("os_high", highs[0], 96);
    check_val("os_rise", rises[0], 1);
    check_val("os_done_cnt", dones[0], 1);
    check_val("os_fall_at", fall_at[0], 97);
    check_val("os_done_at", done_at[0], 97);
    cfg_read(16, 0, "os_mode_clr");

    // Register readback and full-on mode
    cfg_write(16, 3);
    cfg_read(0, 3, "rd_duty0");
    cfg_read(1, 4, "rd_duty1");
    cfg_read(2, 0, "rd_duty2");
    cfg_read(16, 3, "rd_mode0");
    cfg_read(17, 1, "rd_mode1");
    cfg_read(18, 1, "rd_mode2");
    cfg_read(7, 0, "rd_hole7");
    wait_tick();
    run(32, -1, 0, 0);
    check_val("on0_high", highs[0], 32);
    bus.cfg_we    = 1'b1;
    bus.cfg_re    = 1'b1;
    bus.cfg_addr  = 5'd1;
    bus.cfg_wdata = 4'd9;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    bus.cfg_re = 1'b0;
    check_val("rw_same_old", int'(bus.cfg_rdata), 4);
    @(negedge clk);
    cfg_read(1, 9, "rw_same_new");
    cfg_write(16, 0);

    // Reset in the middle of a one-shot
    cfg_write(0, 5);
    cfg_write(16, 2);
    wait_tick();
    run(50, -1, 0, 0);
    check_val("os5_running", int'(pwm_out[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_pwm", int'(pwm_out), 0);
    check_val("arst_done", int'(oneshot_done), 0);
    rst_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (oneshot_done != 3'b000) rst_done++;
    end
    rst_n = 1'b1;
    check_val("arst_no_done", rst_done, 0);
    cfg_read(0, 0, "arst_duty0");
    cfg_read(16, 0, "arst_mode0");
    cfg_read(17, 0, "arst_mode1");
    run(40, -1, 0, 0);
    check_val("arst_quiet", highs[0] + highs[1] + highs[2], 0);
    check_val("arst_quiet_done", dones[0] + dones[1] + dones[2], 0);

    // Period tick count and spacing
    wait_tick();
    run(320, -1, 0, 0);
    check_val("tick_count", ticks, 10);
    check_val("tick_spacing", bad_gap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator that replaces the fixed shutter and Peltier PWM outputs of the camera controller with one configurable bank. Each channel has a double-buffered duty register, a selectable mode (off, PWM, one-shot pulse train, full-on) and a glitch-free update at period boundaries. The bank sits behind the command decoder's register-write path, fed from the FT245 command stream, and drives the `pwm_*` pins directly.

## Interface
- `N_CH`, 3, number of channels (1..8); channel 0 = shutter, 1/2 = Peltier 1/2.
- `WIDTH`, 8, duty/counter width in bits (2..16); period = 2^WIDTH ticks.
- `PRESCALE`, 4, clk cycles per tick (≥1); 1 = tick every cycle.
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  register write strobe, one cycle.
- `cfg_re`  in  1  register read strobe, one cycle.
- `cfg_addr`  in  5  register address.
- `cfg_wdata`  in  WIDTH  write data.
- `cfg_rdata`  out  WIDTH  read data, valid the cycle after `cfg_re`.
- `cfg_rvalid`  out  1  one-cycle pulse qualifying `cfg_rdata`.
- `pwm_out`  out  N_CH  registered PWM outputs.
- `period_tick`  out  1  one-cycle pulse at every period wrap.
- `oneshot_done`  out  N_CH  one-cycle pulse per channel when a one-shot completes.

## Operation
- Register map: addr 0..N_CH-1 = shadow duty[i]; addr 16..16+N_CH-1 = mode[i] (bits [1:0]); others: writes ignored, reads return 0.
- Modes: 0 OFF (output 0), 1 PWM, 2 ONESHOT, 3 ON (output 1).
- Prescaler `pre` counts 0..PRESCALE-1; `tick` when `pre`==PRESCALE-1.
- Counter `cnt` (WIDTH bits) increments on tick, wraps 2^WIDTH-1 → 0; wrap = tick && `cnt`==all-ones.
- At wrap: active_duty[i] ← shadow duty[i] for all i, simultaneously; mode changes also latch to active mode only at wrap.
- PWM: `pwm_out[i]` = (`cnt` < active_duty[i]); duty 0 → constant low, duty 2^WIDTH-1 → high 2^WIDTH-1 of 2^WIDTH ticks.
- ONESHOT: at the wrap that activates mode 2, remaining[i] ← active duty; output high for full periods while remaining>0, decrementing at each wrap; when it reaches 0 output goes low, `oneshot_done[i]` pulses, shadow and active mode[i] clear to 0 (OFF). Duty 0 in ONESHOT → immediate done, output never rises.
- Writing mode 2 again while a one-shot is running restarts it at the next wrap with current shadow duty.
- Write to mode while one-shot active with value ≠2: takes effect at next wrap, no `oneshot_done`.
- Simultaneous `cfg_we` and auto-clear on same cycle: host write wins.
- `cfg_re` and `cfg_we` same cycle, same address: read returns the old value.
- Reads return shadow values (not active).

## Timing
- Reset (async assert, sync deassert expected externally): `pre`,`cnt`=0; all duty, mode, remaining = 0; `pwm_out`=0, `cfg_rdata`=0, `cfg_rvalid`=0, `period_tick`=0, `oneshot_done`=0.
- Shadow register updated on the clock edge sampling `cfg_we`.
- `pwm_out` registered: reflects `cnt`/active state with 1-cycle latency; `period_tick` and active-register load occur on the same edge as the `cnt` wrap.
- `oneshot_done` pulses in the same cycle `pwm_out[i]` falls.
- Reset mid-period or mid-one-shot: all outputs low immediately, no done pulse.
- Period length = PRESCALE·2^WIDTH clk cycles exactly; no drift.

## Test plan
Bench parameters: N_CH=3, WIDTH=4, PRESCALE=2 (period = 32 clk).
- Write duty[1]=4, mode[1]=1 → from the second wrap, `pwm_out[1]` high 8 clk, low 24 clk per period; channels 0/2 stay low.
- Write duty[2]=15 mode[2]=1, then duty[2]=0 mid-period → current period unchanged (high 30 clk), next period constant low; no runt pulse.
- duty[0]=3, mode[0]=2 → `pwm_out[0]` high exactly 96 clk from a wrap, then low, `oneshot_done[0]` one pulse, read addr 16 returns 0.
- mode[0]=3 and mode[0]=0 toggled; read addr 0..2, 16..18, 7 → shadow values, addr 7 returns 0, `cfg_rvalid` one cycle after each `cfg_re`.
- Assert `rst_n`=0 during an active one-shot at cycle 50 → all outputs 0 asynchronously, registers 0 after release, no `oneshot_done`.
- Count `period_tick` over 320 clk → exactly 10 pulses, spaced 32 clk.
